// File: rtl/reg_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_op_sequencer_pkg
// Description : Op-codes, state encoding and defaults shared by the
//               register-operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_op_sequencer_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 2;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_CLR = 3'd1;
   localparam logic [2:0] OP_LD  = 3'd2;
   localparam logic [2:0] OP_INC = 3'd3;
   localparam logic [2:0] OP_DEC = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_ROR = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // CLR and LD are idempotent, so repeating them is pointless
   function automatic logic is_single_step(input logic [2:0] op);
      return (op == OP_CLR) || (op == OP_LD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_op_sequencer
// Description : Accepts one register command per valid/ready handshake and
//               expands it into one register strobe per cycle for
//               cmd_cnt+1 steps, then pulses done for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_op_sequencer
   import reg_op_sequencer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [WIDTH-1:0] reg_q,
   output logic             cl,
   output logic             ld,
   output logic             inc,
   output logic             dec,
   output logic             sr,
   output logic             sl,
   output logic [WIDTH-1:0] in,
   output logic             ir,
   output logic             il,
   output logic             done
);

   state_e           state_q, state_d;
   logic [2:0]       op_q,    op_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // Only the LSB of the register feeds back (rotate-right wrap bit)
   logic unused_reg_hi;
   assign unused_reg_hi = ^reg_q[WIDTH-1:1];

   // Next-state and latched-field computation
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               cnt_d   = is_single_step(cmd_op) ? '0 : cmd_cnt;
               state_d = (cmd_op == OP_NOP) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // Last step is the one that observes a zero remaining count
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched command registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // Strobe decode from registered state; ROR's ir follows reg_q live so each
   // rotate step sees the value produced by the previous one
   always_comb begin
      cl        = 1'b0;
      ld        = 1'b0;
      inc       = 1'b0;
      dec       = 1'b0;
      sr        = 1'b0;
      sl        = 1'b0;
      in        = '0;
      ir        = 1'b0;
      il        = 1'b0;
      cmd_ready = (state_q == ST_IDLE);
      done      = (state_q == ST_DONE);
      if (state_q == ST_RUN) begin
         case (op_q)
            OP_CLR: cl = 1'b1;
            OP_LD: begin
               ld = 1'b1;
               in = data_q;
            end
            OP_INC: inc = 1'b1;
            OP_DEC: dec = 1'b1;
            OP_SHR: begin
               sr = 1'b1;
               ir = data_q[0];
            end
            OP_SHL: begin
               sl = 1'b1;
               il = data_q[0];
            end
            OP_ROR: begin
               sr = 1'b1;
               ir = reg_q[0];
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_op_sequencer
// Description : Directed bench for reg_op_sequencer driving a behavioural
//               4-bit general register; checks strobes, reg_q and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_op_sequencer;

   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_CL   = 6'b100000;
   localparam logic [5:0] S_LD   = 6'b010000;
   localparam logic [5:0] S_INC  = 6'b001000;
   localparam logic [5:0] S_DEC  = 6'b000100;
   localparam logic [5:0] S_SR   = 6'b000010;
   localparam logic [5:0] S_SL   = 6'b000001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_data;
   logic [1:0] cmd_cnt;
   logic [3:0] reg_q = 4'h0;
   logic       cl, ld, inc, dec, sr, sl, ir, il, done;
   logic [3:0] in_w;
   logic [5:0] stb;

   int total = 0;
   int bad   = 0;

   assign stb = {cl, ld, inc, dec, sr, sl};

   always #5 clk = ~clk;

   reg_op_sequencer #(.WIDTH(4), .CNT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_cnt   (cmd_cnt),
      .reg_q     (reg_q),
      .cl        (cl),
      .ld        (ld),
      .inc       (inc),
      .dec       (dec),
      .sr        (sr),
      .sl        (sl),
      .in        (in_w),
      .ir        (ir),
      .il        (il),
      .done      (done)
   );

   // Behavioural general register with one-hot-priority strobes
   always_ff @(posedge clk) begin
      if (cl)       reg_q <= 4'h0;
      else if (ld)  reg_q <= in_w;
      else if (inc) reg_q <= reg_q + 4'h1;
      else if (dec) reg_q <= reg_q - 4'h1;
      else if (sr)  reg_q <= {ir, reg_q[3:1]};
      else if (sl)  reg_q <= {reg_q[2:0], il};
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command in IDLE, take it on the next edge, then drop valid
   task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_cnt   = c;
      chk("ready_before_accept", {7'd0, cmd_ready}, 8'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   // Full command: per-step strobe/in/ir/il checks, reg_q after each step,
   // then one-cycle done and return to IDLE.  regs holds expected reg_q per
   // step (MS nibble first); bits holds expected ir/il per step (MSB first).
   task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] d,
                          input logic [1:0] c, input logic [5:0] exp_stb, input int n,
                          input logic [15:0] regs, input logic [3:0] bits);
      issue(op, d, c);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_stb"},   {2'd0, stb}, {2'd0, exp_stb});
         chk({tag, "_ready"}, {7'd0, cmd_ready}, 8'd0);
         chk({tag, "_done"},  {7'd0, done}, 8'd0);
         chk({tag, "_in"},    {4'd0, in_w}, (exp_stb == S_LD) ? {4'd0, d} : 8'd0);
         chk({tag, "_ir"},    {7'd0, ir}, (exp_stb == S_SR) ? {7'd0, bits[3-i]} : 8'd0);
         chk({tag, "_il"},    {7'd0, il}, (exp_stb == S_SL) ? {7'd0, bits[3-i]} : 8'd0);
         tick();
         chk({tag, "_reg"},   {4'd0, reg_q}, {4'd0, regs[15-4*i -: 4]});
      end
      chk({tag, "_done_hi"},   {7'd0, done}, 8'd1);
      chk({tag, "_done_stb"},  {2'd0, stb}, 8'd0);
      chk({tag, "_done_rdy"},  {7'd0, cmd_ready}, 8'd0);
      tick();
      chk({tag, "_idle_done"}, {7'd0, done}, 8'd0);
      chk({tag, "_idle_rdy"},  {7'd0, cmd_ready}, 8'd1);
      chk({tag, "_idle_stb"},  {2'd0, stb}, 8'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 4'h0;
      cmd_cnt   = 2'd0;
      #12;
      chk("rst_stb",  {2'd0, stb}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_in",   {4'd0, in_w}, 8'd0);
      chk("rst_irl",  {6'd0, ir, il}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", {7'd0, cmd_ready}, 8'd1);

      // LD ignores its count: one step, done two cycles after accept
      run_cmd("ld_a",  3'd2, 4'hA, 2'd3, S_LD,  1, 16'hA000, 4'b0000);
      run_cmd("ld_e",  3'd2, 4'hE, 2'd0, S_LD,  1, 16'hE000, 4'b0000);
      // INC x4 wraps through 0
      run_cmd("inc4",  3'd3, 4'h0, 2'd3, S_INC, 4, 16'hF012, 4'b0000);
      // CLR ignores its count
      run_cmd("clr",   3'd1, 4'h5, 2'd2, S_CL,  1, 16'h0000, 4'b0000);
      // SHR x2 with fill 1 from 0
      run_cmd("shr2",  3'd5, 4'h1, 2'd1, S_SR,  2, 16'h8C00, 4'b1100);
      run_cmd("ld_3",  3'd2, 4'h3, 2'd0, S_LD,  1, 16'h3000, 4'b0000);
      // SHL x2 with fill from data[0]=0 (upper data bits set, must not matter)
      run_cmd("shl2",  3'd6, 4'hE, 2'd1, S_SL,  2, 16'h6C00, 4'b0000);
      run_cmd("ld_1",  3'd2, 4'h1, 2'd0, S_LD,  1, 16'h1000, 4'b0000);
      // ROR x4 from 1: ir follows reg_q[0], data[0]=0 must not leak in
      run_cmd("ror4",  3'd7, 4'h0, 2'd3, S_SR,  4, 16'h8421, 4'b1000);

      // NOP with valid held; next command waits for IDLE
      cmd_valid = 1'b1;
      cmd_op    = 3'd0;
      cmd_data  = 4'h0;
      cmd_cnt   = 2'd0;
      chk("nop_rdy0", {7'd0, cmd_ready}, 8'd1);
      tick();
      chk("nop_done", {7'd0, done}, 8'd1);
      chk("nop_stb",  {2'd0, stb}, 8'd0);
      chk("nop_busy", {7'd0, cmd_ready}, 8'd0);
      cmd_op  = 3'd4;
      cmd_cnt = 2'd0;
      tick();
      chk("q_idle_rdy",  {7'd0, cmd_ready}, 8'd1);
      chk("q_idle_stb",  {2'd0, stb}, 8'd0);
      chk("q_idle_done", {7'd0, done}, 8'd0);
      tick();
      chk("q_dec_stb", {2'd0, stb}, {2'd0, S_DEC});
      chk("q_dec_rdy", {7'd0, cmd_ready}, 8'd0);
      cmd_valid = 1'b0;
      tick();
      chk("q_dec_reg",  {4'd0, reg_q}, 8'h00);
      chk("q_dec_done", {7'd0, done}, 8'd1);
      tick();
      chk("q_end_rdy", {7'd0, cmd_ready}, 8'd1);

      // Reset in the middle of DEC x4
      issue(3'd4, 4'h0, 2'd3);
      chk("rd_stb1", {2'd0, stb}, {2'd0, S_DEC});
      tick();
      chk("rd_reg1", {4'd0, reg_q}, 8'h0F);
      chk("rd_stb2", {2'd0, stb}, {2'd0, S_DEC});
      #3;
      rst_n = 1'b0;
      #1;
      chk("rd_async_stb",  {2'd0, stb}, 8'd0);
      chk("rd_async_done", {7'd0, done}, 8'd0);
      tick();
      chk("rd_hold_reg",  {4'd0, reg_q}, 8'h0F);
      chk("rd_hold_done", {7'd0, done}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rd_rel_rdy",  {7'd0, cmd_ready}, 8'd1);
      chk("rd_rel_done", {7'd0, done}, 8'd0);
      chk("rd_rel_stb",  {2'd0, stb}, 8'd0);
      tick();
      chk("rd_rel_done2", {7'd0, done}, 8'd0);
      chk("rd_rel_reg",   {4'd0, reg_q}, 8'h0F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run can never hang
   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Control stage directly upstream of the 4-bit general register. The register takes one-hot-priority strobes: cl, ld, inc, dec, sr/ir, sl/il.
- Accepts one register command per valid/ready handshake and expands it into one strobe per cycle for a programmable repeat count.
- Reports completion with a one-cycle done pulse. Used by the CPU control path for multi-step register operations: multi-bit shifts, rotates, repeated inc/dec.

Parameters:
- WIDTH, 4, width of the register data path (in, reg_q).
- CNT_W, 2, width of the repeat-count field; steps = cmd_cnt + 1 (1..2^CNT_W).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command (IDLE only).
- cmd_op  input  3  0 NOP, 1 CLR, 2 LD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 ROR.
- cmd_data  input  WIDTH  LD value; bit0 is the fill bit for SHR/SHL.
- cmd_cnt  input  CNT_W  repeat count minus one.
- reg_q  input  WIDTH  current register output, used for ROR feedback.
- cl, ld, inc, dec, sr, sl  output  1 each  register strobes.
- in  output  WIDTH  register load data.
- ir, il  output  1  register shift-in bits.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: single clock domain, clk rising edge. rst_n is asynchronous, active-low.
- Reset values: state IDLE; all latched fields 0; all strobes, ir, il, in, done = 0; cmd_ready = 1 once rst_n deasserts.
- States: IDLE, RUN, DONE.
- IDLE: cmd_ready=1, no strobes.
  - On a clk edge with cmd_valid=1, latch op, data and cnt.
  - NOP goes to DONE. Every other op goes to RUN.
- RUN: cmd_ready=0. Exactly one strobe is asserted per cycle, decoded from latched op:
  - CLR → cl.
  - LD → ld; in = latched data.
  - INC → inc.
  - DEC → dec.
  - SHR → sr; ir = data[0].
  - SHL → sl; il = data[0].
  - ROR → sr; ir = reg_q[0], combinational from reg_q, so each step sees the updated value.
- RUN count handling:
  - CLR and LD execute exactly one step regardless of cnt (cnt forced to 0 at latch).
  - Other ops: remaining counter decrements each RUN cycle. Go to DONE in the cycle it reads 0.
- DONE: done=1 for exactly one cycle, cmd_ready=0, then IDLE.
- Latency: command accepted at edge T.
  - Strobes active in cycles T+1 .. T+1+cnt.
  - done in cycle T+2+cnt.
  - Next accept possible at edge T+3+cnt.
  - NOP: done in cycle T+1.
- Outputs are pure decodes of the registered state and latched fields (ROR's ir excepted). No two strobes are ever high together.
- in and ir/il are 0 whenever the corresponding strobe is low.
- cmd_valid while busy (RUN/DONE) is ignored. The command must be held until cmd_ready, per the standard valid/ready rule.
- Counter arithmetic is unsigned CNT_W bits, with no wrap beyond 0 (exit condition).
- Reset mid-operation: immediate return to IDLE, all strobes drop asynchronously, no done pulse.

Decomposition:
- Shared package: op-code constants (OP_NOP..OP_ROR), state encoding constants, WIDTH/CNT_W defaults.
- No sub-module needed; the strobe decoder may optionally be split out as reg_strobe_decode (pure combinational).

Test Plan:
- Bench instantiates the existing register driven by this block and checks reg_q plus strobe timing.
- LD data=4'hA, cnt=3 from reset → single ld pulse with in=4'hA, reg_q=4'hA, done at T+2, cnt ignored.
- INC cnt=3 with reg_q=4'hE → four inc pulses, reg_q 4'hF,0,1,2 (wrap), done at T+5.
- SHR data[0]=1, cnt=1 from 4'h0 → reg_q 4'h8 then 4'hC, ir=1 on both strobes; SHL data[0]=0, cnt=1 from 4'h3 → 4'h6, 4'hC.
- ROR cnt=3 from 4'h1 → reg_q 4'h8,4,2,1, returns to 4'h1, ir tracks reg_q[0] each cycle.
- cmd_valid held high with two queued commands → cmd_ready low during RUN/DONE, second accepted only in IDLE; NOP yields done at T+1 with no strobe.
- rst_n pulsed low in the middle of DEC cnt=3 → strobes drop immediately, no done, IDLE with cmd_ready=1 after release.
